// File: rtl/moesif_line_controller.sv
// MOESIF coherence controller for NUM_LINES cache lines: serialises processor
// requests onto the bus and services one bus snoop per cycle in any FSM state.
module moesif_line_controller #(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             proc_valid,
    output logic             proc_ready,
    input  logic             proc_write,
    input  logic [IDX_W-1:0] proc_index,
    output logic             proc_done,
    output logic             bus_req_valid,
    output logic [1:0]       bus_req_type,
    output logic [IDX_W-1:0] bus_req_index,
    input  logic             bus_gnt,
    input  logic             bus_shared,
    input  logic             snp_valid,
    input  logic [1:0]       snp_type,
    input  logic [IDX_W-1:0] snp_index,
    output logic             snp_supply,
    output logic             snp_shared,
    input  logic [IDX_W-1:0] dbg_index,
    output logic [2:0]       dbg_state
);

    localparam logic [2:0] ST_I = 3'd0;
    localparam logic [2:0] ST_S = 3'd1;
    localparam logic [2:0] ST_E = 3'd2;
    localparam logic [2:0] ST_M = 3'd3;
    localparam logic [2:0] ST_O = 3'd4;
    localparam logic [2:0] ST_F = 3'd5;

    localparam logic [1:0] REQ_NONE = 2'd0;
    localparam logic [1:0] REQ_RD   = 2'd1;
    localparam logic [1:0] REQ_RDX  = 2'd2;
    localparam logic [1:0] REQ_UPGR = 2'd3;

    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_LOOKUP = 2'd1,
        FSM_BUSREQ = 2'd2
    } fsm_e;

    // Bus handshake: bus_req_valid rises in BUSREQ and holds with a stable
    // index until the cycle bus_gnt is high; the type may only fall from
    // BusUpgr to BusRdX when a snoop has invalidated the line.

    fsm_e             state_q, state_d;
    logic             wr_q, wr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       type_q, type_d;
    logic             done_q, done_d;
    logic             sup_q, sup_d;
    logic             shd_q, shd_d;
    logic [2:0]       line_q [NUM_LINES];
    logic [2:0]       line_d [NUM_LINES];

    logic [2:0]       snp_pre;
    logic [2:0]       snp_post;
    logic             snp_give;
    logic [2:0]       look_state;

    // Encodings 6/7 are never written but read back as Invalid.
    function automatic logic [2:0] clean_state(input logic [2:0] s);
        return (s > ST_F) ? ST_I : s;
    endfunction

    always_comb begin
        snp_pre  = clean_state(line_q[snp_index]);
        snp_post = snp_pre;
        snp_give = 1'b0;
        case (snp_type)
            REQ_RD: begin
                snp_give = (snp_pre != ST_I) && (snp_pre != ST_S);
                case (snp_pre)
                    ST_M:       snp_post = ST_O;
                    ST_E, ST_F: snp_post = ST_S;
                    default:    snp_post = snp_pre;
                endcase
            end
            REQ_RDX: begin
                snp_give = (snp_pre != ST_I) && (snp_pre != ST_S);
                snp_post = ST_I;
            end
            REQ_UPGR: snp_post = ST_I;
            default:  snp_post = snp_pre;
        endcase
    end

    always_comb begin
        line_d  = line_q;
        state_d = state_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        type_d  = type_q;
        done_d  = 1'b0;
        sup_d   = snp_valid && snp_give;
        shd_d   = snp_valid && (snp_pre != ST_I);

        // Snoop lands first so that LOOKUP and the grant both see its effect.
        if (snp_valid) begin
            line_d[snp_index] = snp_post;
        end
        look_state = clean_state(line_d[idx_q]);

        case (state_q)
            FSM_IDLE: begin
                if (proc_valid) begin
                    wr_d    = proc_write;
                    idx_d   = proc_index;
                    state_d = FSM_LOOKUP;
                end
            end
            FSM_LOOKUP: begin
                if (!wr_q && look_state != ST_I) begin
                    done_d  = 1'b1;
                    state_d = FSM_IDLE;
                end else if (wr_q && (look_state == ST_E || look_state == ST_M)) begin
                    line_d[idx_q] = ST_M;
                    done_d        = 1'b1;
                    state_d       = FSM_IDLE;
                end else begin
                    if (look_state == ST_I) begin
                        type_d = wr_q ? REQ_RDX : REQ_RD;
                    end else begin
                        type_d = REQ_UPGR;
                    end
                    state_d = FSM_BUSREQ;
                end
            end
            FSM_BUSREQ: begin
                if (bus_gnt) begin
                    if (type_q == REQ_RD) begin
                        line_d[idx_q] = bus_shared ? ST_F : ST_E;
                    end else begin
                        line_d[idx_q] = ST_M;
                    end
                    done_d  = 1'b1;
                    state_d = FSM_IDLE;
                end else if (type_q == REQ_UPGR && look_state == ST_I) begin
                    type_d = REQ_RDX;
                end
            end
            default: state_d = FSM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FSM_IDLE;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            type_q  <= REQ_NONE;
            done_q  <= 1'b0;
            sup_q   <= 1'b0;
            shd_q   <= 1'b0;
            for (int i = 0; i < NUM_LINES; i++) begin
                line_q[i] <= ST_I;
            end
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            type_q  <= type_d;
            done_q  <= done_d;
            sup_q   <= sup_d;
            shd_q   <= shd_d;
            line_q  <= line_d;
        end
    end

    assign proc_ready    = (state_q == FSM_IDLE);
    assign proc_done     = done_q;
    assign bus_req_valid = (state_q == FSM_BUSREQ);
    assign bus_req_type  = bus_req_valid ? type_q : REQ_NONE;
    assign bus_req_index = bus_req_valid ? idx_q : '0;
    assign snp_supply    = sup_q;
    assign snp_shared    = shd_q;
    assign dbg_state     = clean_state(line_q[dbg_index]);

endmodule
